// File: rtl/fifo_packer_pkg.sv
// Shared types and helpers for the byte-to-word FIFO packer.
// Holds the count-width helper used to size byte counters and idle timers.
package fifo_packer_pkg;

    localparam int MAX_BPW = 16;

    // Number of bits needed to hold every value 0..n.
    function automatic int clog2_cnt(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if (int'(32'd1 << i) <= n) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    typedef logic [clog2_cnt(MAX_BPW)-1:0] packer_cnt_t;
    typedef logic [MAX_BPW*8-1:0]          packer_word_t;

endpackage

// File: rtl/fifo_packer_out_reg.sv
// Output hold register of the packer: loads a packed word and holds it
// stable until the consumer accepts it.
module fifo_packer_out_reg #(
    parameter int BPW = 4,
    parameter int CW  = 3
) (
    input  logic             clock,
    input  logic             aclr_n,
    input  logic             i_load,
    input  logic [8*BPW-1:0] i_data,
    input  logic [CW-1:0]    i_bytes,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [8*BPW-1:0] o_data,
    output logic [CW-1:0]    o_bytes,
    output logic             o_slot_free
);

    logic             r_valid;
    logic [8*BPW-1:0] r_data;
    logic [CW-1:0]    r_bytes;

    // A new word may enter when the slot is empty or is being drained now.
    assign o_slot_free = !r_valid || i_ready;

    // Word hold register; a load takes priority over the handshake clear.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_bytes <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_bytes <= i_bytes;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_bytes = r_bytes;

endmodule

// File: rtl/fifo_byte_word_packer.sv
// Drains a show-ahead byte FIFO and packs bytes little-endian into words.
// Optional idle auto-flush is enabled by defining PACKER_TIMEOUT_FLUSH_EN.
module fifo_byte_word_packer
    import fifo_packer_pkg::*;
#(
    parameter int BYTES_PER_WORD = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                 clock,
    input  logic                                 aclr_n,
    input  logic [7:0]                           fifo_q,
    input  logic                                 fifo_empty,
    output logic                                 fifo_rdreq,
    input  logic                                 flush,
    output logic [8*BYTES_PER_WORD-1:0]          out_data,
    output logic [clog2_cnt(BYTES_PER_WORD)-1:0] out_bytes,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 busy
);

    localparam int            BPW    = BYTES_PER_WORD;
    localparam int            CW     = clog2_cnt(BPW);
    localparam logic [CW-1:0] C_FULL = CW'(BPW);

    if (BPW < 2 || BPW > MAX_BPW) begin : g_bad_bpw
        $error("BYTES_PER_WORD must be in 2..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be positive");
    end

    logic [8*BPW-1:0] r_acc_data;
    logic [CW-1:0]    r_acc_cnt;
    logic             r_flush_pending;
    logic             r_run;
    logic             w_slot_free;
    logic             w_full;
    logic             w_xfer;
    logic             w_pop;
    logic             w_timeout;
    logic [8*BPW-1:0] w_out_word;

    assign w_full = (r_acc_cnt == C_FULL);
    assign w_xfer = w_slot_free && (w_full || (r_flush_pending && (r_acc_cnt != '0)));
    // Popping into a full accumulator is allowed when it empties this same cycle.
    assign w_pop  = r_run && !fifo_empty && !r_flush_pending && (!w_full || w_xfer);

    assign fifo_rdreq = w_pop;
    assign busy       = (r_acc_cnt != '0) || out_valid || r_flush_pending;

    // Zero every lane at or above the byte count before it leaves.
    always_comb begin
        w_out_word = '0;
        for (int i = 0; i < BPW; i++) begin
            if (CW'(i) < r_acc_cnt) begin
                w_out_word[i*8 +: 8] = r_acc_data[i*8 +: 8];
            end else begin
                w_out_word[i*8 +: 8] = 8'h00;
            end
        end
    end

    // Run flop holds off reads for the first clock after reset release.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Accumulator: a byte popped alongside a transfer starts the next word in lane 0.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_acc_data <= '0;
            r_acc_cnt  <= '0;
        end else if (w_xfer) begin
            r_acc_data <= '0;
            if (w_pop) begin
                r_acc_data[7:0] <= fifo_q;
                r_acc_cnt       <= CW'(1);
            end else begin
                r_acc_cnt <= '0;
            end
        end else if (w_pop) begin
            for (int i = 0; i < BPW; i++) begin
                if (CW'(i) == r_acc_cnt) begin
                    r_acc_data[i*8 +: 8] <= fifo_q;
                end
            end
            r_acc_cnt <= r_acc_cnt + CW'(1);
        end
    end

    // Flush request: one outstanding at most; drops without a word if nothing is held.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_flush_pending <= 1'b0;
        end else if (r_flush_pending) begin
            if (w_xfer || (r_acc_cnt == '0)) begin
                r_flush_pending <= 1'b0;
            end
        end else if (flush || w_timeout) begin
            r_flush_pending <= 1'b1;
        end
    end

`ifdef PACKER_TIMEOUT_FLUSH_EN
    localparam int            IW        = clog2_cnt(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] C_TIMEOUT = IW'(TIMEOUT_CYCLES);

    logic [IW-1:0] r_idle_cnt;
    logic          w_idle;

    assign w_idle    = (r_acc_cnt != '0) && !w_pop && !r_flush_pending;
    assign w_timeout = w_idle && (r_idle_cnt == C_TIMEOUT);

    // Idle timer: saturates at the limit; the resulting flush then clears it.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_idle_cnt <= '0;
        end else if (w_pop || w_xfer || !w_idle) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != C_TIMEOUT) begin
            r_idle_cnt <= r_idle_cnt + IW'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    fifo_packer_out_reg #(
        .BPW (BPW),
        .CW  (CW)
    ) u_out_reg (
        .clock       (clock),
        .aclr_n      (aclr_n),
        .i_load      (w_xfer),
        .i_data      (w_out_word),
        .i_bytes     (r_acc_cnt),
        .i_ready     (out_ready),
        .o_valid     (out_valid),
        .o_data      (out_data),
        .o_bytes     (out_bytes),
        .o_slot_free (w_slot_free)
    );

endmodule
